// File: rtl/dsp_pack_unpack.sv
// Unpacks the dual-weight P word from the DSP cascade, accumulates both partial
// sums across input-channel passes and hands results out through a 2-deep buffer.
module dsp_pack_unpack #(
   parameter int LOW_W = 18,
   parameter int P_W   = 48,
   parameter int ACC_W = 32
) (
   input  logic             I_clk,
   input  logic             I_rst,
   input  logic [P_W-1:0]   I_p,
   input  logic             I_p_vld,
   input  logic             I_first,
   input  logic             I_last,
   output logic             O_p_rdy,
   output logic [ACC_W-1:0] O_res_l,
   output logic [ACC_W-1:0] O_res_h,
   output logic             O_res_vld,
   input  logic             I_res_rdy,
   output logic             O_ovf,
   output logic             O_seq_err
);

   localparam int HI_W = P_W - LOW_W;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ACCUM = 1'b1;

   logic             accept;
   logic [ACC_W-1:0] loExt;
   logic [ACC_W-1:0] hiExt;

   logic             s1Vld_q;
   logic             s1First_q;
   logic             s1Last_q;
   logic [ACC_W-1:0] s1Lo_q;
   logic [ACC_W-1:0] s1Hi_q;

   logic [0:0]       state_q, state_d;
   logic [ACC_W-1:0] accL_q, accL_d;
   logic [ACC_W-1:0] accH_q, accH_d;
   logic [ACC_W-1:0] sumL, sumH, accLNext, accHNext;
   logic             startNew, ovfHit, seqHit, push, pop;

   logic [ACC_W-1:0] memL_q [2];
   logic [ACC_W-1:0] memH_q [2];
   logic             wrPtr_q, rdPtr_q;
   logic [1:0]       count_q, count_d;
   logic [1:0]       pending;
   logic             ovf_q, seqErr_q;

   // A negative low field borrows one from the high field, so add its sign bit back.
   always_comb begin
      loExt = {{(ACC_W-LOW_W){I_p[LOW_W-1]}}, I_p[LOW_W-1:0]};
      hiExt = {{(ACC_W-HI_W){I_p[P_W-1]}}, I_p[P_W-1:LOW_W]}
              + {{(ACC_W-1){1'b0}}, I_p[LOW_W-1]};
   end

   // Credits cover buffered results plus the last-beat still in the pipeline.
   assign pending = {1'b0, s1Vld_q & s1Last_q};
   assign O_p_rdy = (count_q + pending) < 2'd2;
   assign accept  = I_p_vld && O_p_rdy;

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         s1Vld_q   <= 1'b0;
         s1First_q <= 1'b0;
         s1Last_q  <= 1'b0;
         s1Lo_q    <= '0;
         s1Hi_q    <= '0;
      end else begin
         s1Vld_q <= accept;
         if (accept) begin
            s1First_q <= I_first;
            s1Last_q  <= I_last;
            s1Lo_q    <= loExt;
            s1Hi_q    <= hiExt;
         end
      end
   end

   // A stray first restarts the group and a missing first is treated as one.
   always_comb begin
      startNew = (state_q == ST_IDLE) || s1First_q;
      sumL     = accL_q + s1Lo_q;
      sumH     = accH_q + s1Hi_q;
      accLNext = startNew ? s1Lo_q : sumL;
      accHNext = startNew ? s1Hi_q : sumH;
      ovfHit   = s1Vld_q && !startNew &&
                 (((accL_q[ACC_W-1] == s1Lo_q[ACC_W-1]) && (sumL[ACC_W-1] != accL_q[ACC_W-1])) ||
                  ((accH_q[ACC_W-1] == s1Hi_q[ACC_W-1]) && (sumH[ACC_W-1] != accH_q[ACC_W-1])));
      seqHit   = s1Vld_q && (((state_q == ST_IDLE) && !s1First_q) ||
                             ((state_q == ST_ACCUM) && s1First_q));
      push     = s1Vld_q && s1Last_q;
      accL_d   = accL_q;
      accH_d   = accH_q;
      state_d  = state_q;
      if (s1Vld_q) begin
         if (s1Last_q) begin
            accL_d  = '0;
            accH_d  = '0;
            state_d = ST_IDLE;
         end else begin
            accL_d  = accLNext;
            accH_d  = accHNext;
            state_d = ST_ACCUM;
         end
      end
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state_q  <= ST_IDLE;
         accL_q   <= '0;
         accH_q   <= '0;
         ovf_q    <= 1'b0;
         seqErr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         accL_q   <= accL_d;
         accH_q   <= accH_d;
         ovf_q    <= ovf_q | ovfHit;
         seqErr_q <= seqErr_q | seqHit;
      end
   end

   assign pop = O_res_vld && I_res_rdy;

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 2'd1;
      end else if (pop && !push) begin
         count_d = count_q - 2'd1;
      end
   end

   // The credit check guarantees a push never meets a full buffer.
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         memL_q[0] <= '0;
         memL_q[1] <= '0;
         memH_q[0] <= '0;
         memH_q[1] <= '0;
         wrPtr_q   <= 1'b0;
         rdPtr_q   <= 1'b0;
         count_q   <= 2'd0;
      end else begin
         if (push) begin
            memL_q[wrPtr_q] <= accLNext;
            memH_q[wrPtr_q] <= accHNext;
            wrPtr_q         <= wrPtr_q + 1'b1;
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
         count_q <= count_d;
      end
   end

   assign O_res_l   = memL_q[rdPtr_q];
   assign O_res_h   = memH_q[rdPtr_q];
   assign O_res_vld = (count_q != 2'd0);
   assign O_ovf     = ovf_q;
   assign O_seq_err = seqErr_q;

endmodule

// File: tb/tb_dsp_pack_unpack.sv
// Directed bench for dsp_pack_unpack: hand-computed unpack, accumulation,
// backpressure, reset and error-flag vectors.
module tb_dsp_pack_unpack;

   logic        I_clk = 1'b0;
   logic        I_rst;
   logic [47:0] I_p;
   logic        I_p_vld;
   logic        I_first;
   logic        I_last;
   logic        O_p_rdy;
   logic [31:0] O_res_l;
   logic [31:0] O_res_h;
   logic        O_res_vld;
   logic        I_res_rdy;
   logic        O_ovf;
   logic        O_seq_err;

   int totalChecks = 0;
   int badChecks   = 0;

   dsp_pack_unpack #(.LOW_W(18), .P_W(48), .ACC_W(32)) dut (
      .I_clk     (I_clk),
      .I_rst     (I_rst),
      .I_p       (I_p),
      .I_p_vld   (I_p_vld),
      .I_first   (I_first),
      .I_last    (I_last),
      .O_p_rdy   (O_p_rdy),
      .O_res_l   (O_res_l),
      .O_res_h   (O_res_h),
      .O_res_vld (O_res_vld),
      .I_res_rdy (I_res_rdy),
      .O_ovf     (O_ovf),
      .O_seq_err (O_seq_err)
   );

   always #5 I_clk = ~I_clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      totalChecks++;
      if (got !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Drives one beat from a negedge and returns right after the accepting posedge.
   task automatic applyStimulus(input logic [47:0] p, input logic f, input logic l);
      int guard;
      @(negedge I_clk);
      I_p     = p;
      I_first = f;
      I_last  = l;
      I_p_vld = 1'b1;
      guard   = 0;
      while (!O_p_rdy && guard < 200) begin
         @(negedge I_clk);
         guard++;
      end
      if (guard >= 200) checkOutput("rdy_timeout", 32'(O_p_rdy), 32'd1);
      @(posedge I_clk);
   endtask

   task automatic waitResult(input string tag, output logic [31:0] l, output logic [31:0] h);
      logic found;
      found = 1'b0;
      l = '0;
      h = '0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge I_clk);
         if (O_res_vld) begin
            found = 1'b1;
            l = O_res_l;
            h = O_res_h;
         end
      end
      checkOutput({tag, "_seen"}, 32'(found), 32'd1);
   endtask

   logic [31:0] resL, resH;
   logic [31:0] gotL [4];
   logic [31:0] gotH [4];
   int          nGot;

   initial begin
      I_rst = 1'b1; I_p = '0; I_p_vld = 1'b0; I_first = 1'b0; I_last = 1'b0; I_res_rdy = 1'b1;
      repeat (2) @(negedge I_clk);
      checkOutput("rst_vld", 32'(O_res_vld), 32'd0);
      checkOutput("rst_l", O_res_l, 32'd0);
      checkOutput("rst_h", O_res_h, 32'd0);
      checkOutput("rst_ovf", 32'(O_ovf), 32'd0);
      checkOutput("rst_seq", 32'(O_seq_err), 32'd0);
      checkOutput("rst_rdy", 32'(O_p_rdy), 32'd1);
      I_rst = 1'b0;

      // Negative high field with exact latency.
      applyStimulus(48'hFFFF_FFD8_000F, 1'b1, 1'b1);
      @(negedge I_clk);
      I_p_vld = 1'b0;
      checkOutput("lat_t1", 32'(O_res_vld), 32'd0);
      @(negedge I_clk);
      checkOutput("lat_t2", 32'(O_res_vld), 32'd1);
      checkOutput("neg_l", O_res_l, 32'd15);
      checkOutput("neg_h", O_res_h, 32'hFFFF_FFF6);

      // Borrow correction.
      applyStimulus(48'h0000_0027_FFF1, 1'b1, 1'b1);
      @(negedge I_clk);
      I_p_vld = 1'b0;
      waitResult("brw", resL, resH);
      checkOutput("brw_l", resL, 32'hFFFF_FFF1);
      checkOutput("brw_h", resH, 32'd10);

      // Three-pass accumulation with a gap before the last pass.
      applyStimulus(48'hFFFF_FFD8_000F, 1'b1, 1'b0);
      applyStimulus(48'hFFFF_FFD8_000F, 1'b0, 1'b0);
      @(negedge I_clk);
      I_p_vld = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge I_clk);
         checkOutput("acc_nores", 32'(O_res_vld), 32'd0);
      end
      applyStimulus(48'hFFFF_FFD8_000F, 1'b0, 1'b1);
      @(negedge I_clk);
      I_p_vld = 1'b0;
      waitResult("acc", resL, resH);
      checkOutput("acc_l", resL, 32'd45);
      checkOutput("acc_h", resH, 32'hFFFF_FFE2);

      // Backpressure: two results fill the credits, then drain all four in order.
      @(negedge I_clk);
      I_res_rdy = 1'b0;
      applyStimulus(48'h0000_0000_0001, 1'b1, 1'b1);
      applyStimulus(48'h0000_0004_0002, 1'b1, 1'b1);
      @(negedge I_clk);
      I_p_vld = 1'b0;
      repeat (3) @(negedge I_clk);
      checkOutput("bp_rdy_low", 32'(O_p_rdy), 32'd0);
      checkOutput("bp_vld", 32'(O_res_vld), 32'd1);
      checkOutput("bp_head_l", O_res_l, 32'd1);
      nGot = 0;
      fork
         begin
            applyStimulus(48'h0000_0008_0003, 1'b1, 1'b1);
            applyStimulus(48'h0000_000C_0004, 1'b1, 1'b1);
            @(negedge I_clk);
            I_p_vld = 1'b0;
         end
         begin
            I_res_rdy = 1'b1;
            repeat (30) begin
               if (O_res_vld) begin
                  if (nGot < 4) begin
                     gotL[nGot] = O_res_l;
                     gotH[nGot] = O_res_h;
                  end
                  nGot++;
               end
               @(negedge I_clk);
            end
         end
      join
      checkOutput("bp_count", 32'(nGot), 32'd4);
      for (int i = 0; i < 4 && i < nGot; i++) begin
         checkOutput("bp_l", gotL[i], 32'(i + 1));
         checkOutput("bp_h", gotH[i], 32'(i));
      end

      // Reset in the middle of a group.
      applyStimulus(48'hFFFF_FFD8_000F, 1'b1, 1'b0);
      @(negedge I_clk);
      I_p_vld = 1'b0;
      I_rst   = 1'b1;
      @(negedge I_clk);
      checkOutput("mrst_vld", 32'(O_res_vld), 32'd0);
      checkOutput("mrst_l", O_res_l, 32'd0);
      checkOutput("mrst_h", O_res_h, 32'd0);
      I_rst = 1'b0;
      applyStimulus(48'h0000_0027_FFF1, 1'b1, 1'b1);
      @(negedge I_clk);
      I_p_vld = 1'b0;
      waitResult("mrst", resL, resH);
      checkOutput("mrst_res_l", resL, 32'hFFFF_FFF1);
      checkOutput("mrst_res_h", resH, 32'd10);
      checkOutput("mrst_seq", 32'(O_seq_err), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge I_clk);
         checkOutput("mrst_extra", 32'(O_res_vld), 32'd0);
      end

      // Missing first in IDLE still yields a result.
      applyStimulus(48'hFFFF_FFD8_000F, 1'b0, 1'b1);
      @(negedge I_clk);
      I_p_vld = 1'b0;
      waitResult("seq", resL, resH);
      checkOutput("seq_l", resL, 32'd15);
      checkOutput("seq_h", resH, 32'hFFFF_FFF6);
      checkOutput("seq_flag", 32'(O_seq_err), 32'd1);

      // Low accumulator reaches 2^31-1, then one more wraps it.
      applyStimulus(48'h0000_0001_FFFF, 1'b1, 1'b0);
      for (int i = 0; i < 16383; i++) applyStimulus(48'h0000_0001_FFFF, 1'b0, 1'b0);
      applyStimulus(48'h0000_0000_3FFF, 1'b0, 1'b0);
      @(negedge I_clk);
      I_p_vld = 1'b0;
      @(negedge I_clk);
      checkOutput("ovf_before", 32'(O_ovf), 32'd0);
      applyStimulus(48'h0000_0000_0001, 1'b0, 1'b1);
      @(negedge I_clk);
      I_p_vld = 1'b0;
      waitResult("ovf", resL, resH);
      checkOutput("ovf_l", resL, 32'h8000_0000);
      checkOutput("ovf_h", resH, 32'd0);
      checkOutput("ovf_flag", 32'(O_ovf), 32'd1);
      repeat (3) @(negedge I_clk);
      checkOutput("ovf_sticky", 32'(O_ovf), 32'd1);
      checkOutput("seq_sticky", 32'(O_seq_err), 32'd1);

      I_rst = 1'b1;
      @(negedge I_clk);
      checkOutput("clr_ovf", 32'(O_ovf), 32'd0);
      checkOutput("clr_seq", 32'(O_seq_err), 32'd0);
      checkOutput("clr_rdy", 32'(O_p_rdy), 32'd1);
      I_rst = 1'b0;
      @(negedge I_clk);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
